// File: rtl/rlbp_pkg.sv
// Shared types for the RLBP readout path.
//   cap_state_e : capture state machine states
//   N_PD_DEF    : default number of photodiode comparisons per frame
//   lbp_code_t  : one assembled LBP code word (PD1 = bit 0)
package rlbp_pkg;

  localparam int N_PD_DEF = 12;

  typedef logic [N_PD_DEF-1:0] lbp_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BIT,
    ST_SETTLE,
    ST_PUSH
  } cap_state_e;

endpackage

// File: rtl/rlbp_code_fifo.sv
// Small synchronous FIFO for completed codes, shared with later readout stages.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping too)
//   pop        : read request (ignored when empty)
//   dout       : head entry, valid while empty is low
//   full/empty : occupancy flags
module rlbp_code_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still accepted when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rlbp_code_capture.sv
// Samples the asynchronous comparator once per photodiode strobe, assembles
// N_PD results into an LBP code and queues finished codes for the bus side.
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   cmp_out_i           : raw comparator output (asynchronous)
//   start_i             : begin (or restart) a frame
//   bit_strobe_i        : comparator is evaluating the current photodiode
//   code_o/code_valid_o/code_ready_i : FIFO head with valid/ready handshake
//   busy_o              : frame in progress
//   done_o              : frame completed (code stored or dropped)
//   overflow_o/clr_ovf_i: sticky dropped-code flag and its clear
module rlbp_code_capture
  import rlbp_pkg::*;
#(
  parameter int N_PD   = N_PD_DEF,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmp_out_i,
  input  logic            start_i,
  input  logic            bit_strobe_i,
  output logic [N_PD-1:0] code_o,
  output logic            code_valid_o,
  input  logic            code_ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            overflow_o,
  input  logic            clr_ovf_i
);

  localparam int IW = $clog2(N_PD);
  localparam int CW = $clog2(SETTLE) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PD - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

  cap_state_e      state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N_PD-1:0] shreg, shreg_n;
  logic            sync_ff, cmp_s;
  logic            push, pop, full, empty, ovf_evt;

  // Two-flop synchronizer for the comparator output.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_ff <= 1'b0;
      cmp_s   <= 1'b0;
    end else begin
      sync_ff <= cmp_out_i;
      cmp_s   <= sync_ff;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
    end
  end

  // A start in any state (re)opens a frame; in PUSH the current code is
  // still pushed in that cycle, so the finished frame is never lost.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    shreg_n = shreg;
    push    = 1'b0;
    done_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_n = ST_WAIT_BIT;
          idx_n   = '0;
          shreg_n = '0;
        end
      end
      ST_WAIT_BIT: begin
        if (start_i) begin
          idx_n   = '0;
          shreg_n = '0;
        end else if (bit_strobe_i) begin
          state_n = ST_SETTLE;
          cnt_n   = CNT_INIT;
        end
      end
      ST_SETTLE: begin
        if (start_i) begin
          state_n = ST_WAIT_BIT;
          idx_n   = '0;
          shreg_n = '0;
        end else if (cnt == '0) begin
          shreg_n[idx] = cmp_s;
          if (idx == LAST_IDX) begin
            state_n = ST_PUSH;
          end else begin
            idx_n   = idx + IW'(1);
            state_n = ST_WAIT_BIT;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_PUSH: begin
        push   = 1'b1;
        done_o = 1'b1;
        if (start_i) begin
          state_n = ST_WAIT_BIT;
          idx_n   = '0;
          shreg_n = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy_o       = (state != ST_IDLE);
  assign code_valid_o = !empty;
  assign pop          = code_valid_o && code_ready_i;

  // A code is dropped only when full and the head is not leaving this cycle.
  assign ovf_evt = push && full && !pop;

  // Sticky overflow; a new event beats a simultaneous clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      overflow_o <= 1'b0;
    end else if (ovf_evt) begin
      overflow_o <= 1'b1;
    end else if (clr_ovf_i) begin
      overflow_o <= 1'b0;
    end
  end

  rlbp_code_fifo #(
    .WIDTH (N_PD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .dout  (code_o),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_rlbp_code_capture.sv
// Self-checking bench for rlbp_code_capture: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// frame-level behavioural model.
module tb_rlbp_code_capture;
  import rlbp_pkg::*;

  localparam int N_PD   = 12;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b1;
  logic            cmp    = 1'b0;
  logic            start  = 1'b0;
  logic            strobe = 1'b0;
  logic            ready  = 1'b0;
  logic            clr    = 1'b0;
  logic [N_PD-1:0] code;
  logic            valid, busy, done, ovf;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  rlbp_code_capture #(
    .N_PD   (N_PD),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .cmp_out_i    (cmp),
    .start_i      (start),
    .bit_strobe_i (strobe),
    .code_o       (code),
    .code_valid_o (valid),
    .code_ready_i (ready),
    .busy_o       (busy),
    .done_o       (done),
    .overflow_o   (ovf),
    .clr_ovf_i    (clr)
  );

  // Shared comparison routine used by directed checks and the model compare.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a sequence of accepted strobes, each bit
  // taking the comparator value seen SETTLE edges later through a 2-deep
  // synchronizer delay; completed codes go into a bounded queue.
  lbp_code_t m_q[$];
  lbp_code_t m_acc    = '0;
  bit        m_ovf    = 1'b0;
  bit        m_active = 1'b0;
  bit        m_wait   = 1'b0;
  bit        m_push   = 1'b0;
  bit        m_s1     = 1'b0;
  bit        m_s2     = 1'b0;
  bit        m_pop, m_evt;
  int        m_nbits  = 0;
  int        m_left   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_acc = '0; m_ovf = 0; m_active = 0; m_wait = 0; m_push = 0;
      m_s1 = 0; m_s2 = 0; m_nbits = 0; m_left = 0;
    end else begin
      m_pop = (m_q.size() > 0) && ready;
      m_evt = 0;
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_acc);
        else m_evt = 1;
        m_push = 0;
        if (start) begin
          m_active = 1; m_wait = 1; m_nbits = 0; m_acc = '0;
        end
      end else if (start) begin
        m_active = 1; m_wait = 1; m_nbits = 0; m_acc = '0;
      end else if (m_active && m_wait) begin
        if (strobe) begin
          m_wait = 0;
          m_left = SETTLE;
        end
      end else if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          m_acc[m_nbits] = m_s2;
          m_nbits++;
          if (m_nbits == N_PD) begin
            m_active = 0;
            m_push   = 1;
          end else begin
            m_wait = 1;
          end
        end
      end
      if (m_evt) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_s2 = m_s1;
      m_s1 = cmp;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busy", busy, m_active || m_push);
      checkOutput("done", done, m_push);
      checkOutput("valid", valid, m_q.size() > 0);
      checkOutput("overflow", ovf, m_ovf);
      if (m_q.size() > 0) checkOutput("code", code, m_q[0]);
    end
  end

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one frame: start pulse, then nbits strobes with the comparator held
  // at the bit value for 3 cycles before each strobe; optionally a second
  // strobe one cycle after each accepted one.
  task automatic applyStimulus(input logic [N_PD-1:0] c, input int nbits, input bit extra);
    logic [N_PD-1:0] cv;
    cv = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      cmp = cv[k];
      repeat (3) tick();
      strobe = 1'b1;
      tick();
      if (extra) tick();
      strobe = 1'b0;
    end
  endtask

  // Bounded wait for done_o; optionally pops during the PUSH cycle.
  task automatic waitDone(input bit pop_at_push);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    checkOutput("done_seen", seen, 1);
    if (pop_at_push && seen) begin
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end else begin
      tick();
    end
  endtask

  task automatic popCheck(input logic [N_PD-1:0] exp);
    checkOutput("pop_valid", valid, 1);
    checkOutput("pop_code", code, exp);
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    #200000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_code", code, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single frame into an empty FIFO.
    applyStimulus(12'hA5C, 12, 1'b0);
    waitDone(1'b0);
    checkOutput("a5c_code", code, 12'hA5C);
    checkOutput("a5c_valid", valid, 1);
    checkOutput("a5c_ovf", ovf, 0);
    checkOutput("model_a5c_depth", m_q.size(), 1);
    checkOutput("model_a5c_code", m_q[0], 12'hA5C);
    popCheck(12'hA5C);
    checkOutput("a5c_empty", valid, 0);

    // Five frames with no consumer: the fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(12'(1 << i), 12, 1'b0);
      waitDone(1'b0);
      if (i == 3) checkOutput("ovf_before", ovf, 0);
    end
    checkOutput("ovf_set", ovf, 1);
    checkOutput("model_ovf_set", m_ovf, 1);
    popCheck(12'h001);
    popCheck(12'h002);
    popCheck(12'h004);
    popCheck(12'h008);
    checkOutput("ovf_drained", valid, 0);
    checkOutput("ovf_still", ovf, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("ovf_cleared", ovf, 0);

    // Full FIFO with a pop in the PUSH cycle.
    applyStimulus(12'h011, 12, 1'b0); waitDone(1'b0);
    applyStimulus(12'h022, 12, 1'b0); waitDone(1'b0);
    applyStimulus(12'h044, 12, 1'b0); waitDone(1'b0);
    applyStimulus(12'h088, 12, 1'b0); waitDone(1'b0);
    applyStimulus(12'h0FF, 12, 1'b0); waitDone(1'b1);
    checkOutput("simul_ovf", ovf, 0);
    popCheck(12'h022);
    popCheck(12'h044);
    popCheck(12'h088);
    popCheck(12'h0FF);
    checkOutput("simul_empty", valid, 0);

    // Restart after 5 strobes.
    d0 = done_cnt;
    applyStimulus(12'h155, 5, 1'b0);
    applyStimulus(12'h3C3, 12, 1'b0);
    waitDone(1'b0);
    checkOutput("restart_dones", done_cnt - d0, 1);
    popCheck(12'h3C3);
    checkOutput("restart_empty", valid, 0);

    // Extra strobe during SETTLE.
    applyStimulus(12'h6B1, 12, 1'b1);
    waitDone(1'b0);
    popCheck(12'h6B1);
    checkOutput("extra_empty", valid, 0);

    // Asynchronous reset mid-frame with two codes queued.
    applyStimulus(12'h123, 12, 1'b0); waitDone(1'b0);
    applyStimulus(12'h456, 12, 1'b0); waitDone(1'b0);
    applyStimulus(12'h7FF, 7, 1'b0);
    checkOutput("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_valid", valid, 0);
    checkOutput("midrst_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(12'h5A6, 12, 1'b0);
    waitDone(1'b0);
    popCheck(12'h5A6);
    checkOutput("post_rst_empty", valid, 0);

    // Randomized phase checked by the model every cycle.
    for (int n = 0; n < 6000; n++) begin
      start  = ($urandom_range(0, 149) == 0);
      strobe = ($urandom_range(0, 2) == 0);
      cmp    = 1'($urandom);
      ready  = ($urandom_range(0, 3) == 0);
      clr    = ($urandom_range(0, 39) == 0);
      tick();
    end
    start = 0; strobe = 0; ready = 0; clr = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rlbp_code_capture.md
# rlbp_code_capture

Digital capture stage downstream of the pixel analog chain. Samples the asynchronous comparator output `CMP_out_c` once per photodiode comparison and assembles the 12 results of one readout frame into an LBP code word. Completed codes are buffered in a small FIFO and drained by the register/Wishbone side of `rlbp_macro` through a valid/ready handshake.

## Interface
- `N_PD`, 12: comparison bits per frame (one per photodiode, PD1 = bit 0).
- `DEPTH`, 4: code FIFO entries (power of two, ≥2).
- `SETTLE`, 2: cycles from `bit_strobe_i` to the capture of the synchronized comparator value (≥1).
- `wb_clk_i  in  1`: sole clock.
- `wb_rst_ni  in  1`: asynchronous active-low reset.
- `cmp_out_i  in  1`: raw comparator output, asynchronous to `wb_clk_i`.
- `start_i  in  1`: one-cycle pulse that begins a frame.
- `bit_strobe_i  in  1`: one-cycle pulse meaning the comparator is evaluating the current photodiode.
- `code_o  out  N_PD`: FIFO head code.
- `code_valid_o  out  1`: FIFO not empty.
- `code_ready_i  in  1`: consumer accepts `code_o` when high together with `code_valid_o`.
- `busy_o  out  1`: frame in progress (state ≠ IDLE).
- `done_o  out  1`: one-cycle pulse when a frame completes, whether the code was stored or dropped.
- `overflow_o  out  1`: sticky. Set when a completed code is dropped because the FIFO is full.
- `clr_ovf_i  in  1`: clears `overflow_o`.

## Operation
- `cmp_out_i` passes through a 2-flop synchronizer, giving `cmp_s`.
- State machine with states IDLE, WAIT_BIT, SETTLE, PUSH:
  - IDLE: `start_i` → WAIT_BIT. This clears the shift register and sets the bit index to 0.
  - WAIT_BIT: `bit_strobe_i` → SETTLE. This loads the settle counter with `SETTLE-1`.
  - SETTLE: counts down. At 0, `cmp_s` is written into `shreg[idx]`. If `idx == N_PD-1` → PUSH; otherwise `idx++` and → WAIT_BIT.
  - PUSH: writes `shreg` to the FIFO if it is not full; otherwise sets `overflow_o`. Asserts `done_o` and → IDLE.
- `bit_strobe_i` is ignored outside WAIT_BIT.
- `start_i` outside IDLE restarts the frame: partial bits are discarded, `idx` is reset to 0, → WAIT_BIT, and no `done_o` is produced. `start_i` in PUSH takes effect after the push completes, i.e. the frame finishes first.
- FIFO behaviour:
  - Pop occurs on `code_valid_o && code_ready_i`.
  - Simultaneous push and pop when full: both occur, the count is unchanged, and there is no overflow.
  - Read and write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. The count is `log2(DEPTH)+1` bits.
- `clr_ovf_i` and a new overflow event in the same cycle: set wins.
- Reset values: all outputs 0, `code_o` 0, FIFO empty, state IDLE, synchronizer flops 0.
- Reset asserted mid-frame: immediate return to IDLE. Partial data and FIFO contents are lost.

## Timing
- Capture happens `SETTLE` cycles after the `bit_strobe_i` cycle. The sampled value reflects `cmp_out_i` as it was about 2 cycles earlier, because of the synchronizer.
- A minimum of `SETTLE+1` cycles is needed between accepted strobes. Strobes arriving during SETTLE are dropped.
- A completed code is visible on `code_o`/`code_valid_o` 1 cycle after PUSH when the FIFO was empty, since the FIFO is registered.
- `done_o` is high during the PUSH cycle.
- Minimum frame length from `start_i` to `done_o` is `N_PD*(SETTLE+1)+1` cycles.
- `code_o` is stable while `code_valid_o` is high and `code_ready_i` is low.

## Structure
- Package `rlbp_pkg`:
  - state enum `cap_state_e`;
  - `N_PD_DEF = 12`;
  - typedef `lbp_code_t = logic [N_PD_DEF-1:0]`.
- Sub-module `rlbp_code_fifo`: synchronous FIFO with parameters `WIDTH`/`DEPTH`, ports push/pop/full/empty. It is reused by later readout stages.
- The synchronizer is inline (two flops). There is no separate module.

## Test plan
- Pattern 0xA5C: reset, pulse `start_i`, then 12 strobes spaced 4 cycles apart with `cmp_out_i` driven to bit k of 0xA5C (held stable from 3 cycles before each strobe) → `done_o` pulse, `code_o` = 0xA5C, `code_valid_o` = 1, `overflow_o` = 0.
- Overflow: 5 frames (codes 0x001, 0x002, 0x004, 0x008, 0x010) with `code_ready_i` = 0 → the 5th `done_o` sets `overflow_o`. Draining yields 0x001, 0x002, 0x004, 0x008, then `code_valid_o` = 0. `clr_ovf_i` then clears `overflow_o`.
- Full with simultaneous push/pop: FIFO holds 4 codes and `code_ready_i` = 1 during the PUSH of 0x0FF → no overflow, and 0x0FF emerges 4th after the existing entries.
- Restart: `start_i` after 5 strobes, then a full frame of 0x3C3 → exactly one `done_o`, and the FIFO holds only 0x3C3.
- Strobe during SETTLE: an extra strobe 1 cycle after a valid one → ignored. The frame still needs 12 accepted strobes and the code is correct.
- Async reset mid-frame: deassert `wb_rst_ni` for 1 cycle after bit 6 with 2 codes queued → `busy_o`, `code_valid_o` and `overflow_o` are all 0 immediately, and the next full frame works normally.
